// File: rtl/clk_enable_gen_pkg.sv
// clkgen_pkg: FSM state encoding, channel reset defaults and effective divide/phase helpers.
// Helpers work on 32-bit values, so channel fields are limited to CNT_W <= 32.
`timescale 1ns/1ps
package clkgen_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int unsigned DIV_RST   = 1;
    localparam int unsigned PHASE_RST = 0;

    // A zero divide ratio is treated as 1 so every channel always has a finite period.
    function automatic logic [31:0] eff_div_f(input logic [31:0] div);
        return (div == 32'd0) ? 32'd1 : div;
    endfunction

    function automatic logic [31:0] eff_phase_f(input logic [31:0] div, input logic [31:0] phase);
        logic [31:0] max_ph;
        max_ph = eff_div_f(div) - 32'd1;
        return (phase > max_ph) ? max_ph : phase;
    endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// Configuration/strobe bundle for clk_enable_gen; sq exists only with CLKGEN_SQUARE_OUT_EN.
`timescale 1ns/1ps
interface clk_enable_gen_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] ce;
    logic              locked;
`ifdef CLKGEN_SQUARE_OUT_EN
    logic [NUM_CH-1:0] sq;

    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase,
                    input  cfg_ready, ce, locked, sq);
    modport slave  (input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
                    output cfg_ready, ce, locked, sq);
`else
    modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase,
                    input  cfg_ready, ce, locked);
    modport slave  (input  cfg_valid, cfg_ch, cfg_div, cfg_phase,
                    output cfg_ready, ce, locked);
`endif
endinterface

// File: rtl/clk_enable_gen_channel.sv
// clkgen_channel: one enable channel (div/phase registers, down-counter, registered ce/sq).
// Optional square-wave output controlled by CLKGEN_SQUARE_OUT_EN.
`timescale 1ns/1ps
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_phase,
    input  logic             i_run,
    input  logic             i_run_next,
    output logic             o_ce
`ifdef CLKGEN_SQUARE_OUT_EN
    ,
    output logic             o_sq
`endif
);
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_ce;

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_div   <= CNT_W'(DIV_RST);
            r_phase <= CNT_W'(PHASE_RST);
        end else if (i_wr) begin
            r_div   <= CNT_W'(eff_div_f(32'(i_div)));
            r_phase <= CNT_W'(eff_phase_f(32'(i_div), 32'(i_phase)));
        end
    end

    // Outside RUN the counter holds the start value, so the first RUN cycle sees cnt == phase.
    assign w_cnt_next = !i_run           ? r_phase :
                        (r_cnt == '0)    ? r_div - CNT_W'(1) :
                                           r_cnt - CNT_W'(1);

    always_ff @(posedge refclk) begin
        r_cnt <= i_run_next ? w_cnt_next : r_phase;
        if (rst) begin
            r_ce <= 1'b0;
        end else begin
            r_ce <= i_run_next && (w_cnt_next == '0);
        end
    end

    assign o_ce = r_ce;

`ifdef CLKGEN_SQUARE_OUT_EN
    logic r_sq;

    // High on the ce cycle and while the count is in the upper half of the period.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_sq <= 1'b0;
        end else begin
            r_sq <= i_run_next && ((w_cnt_next == '0) || (w_cnt_next > (r_div >> 1)));
        end
    end

    assign o_sq = r_sq;
`endif

endmodule

// File: rtl/clk_enable_gen.sv
// clk_enable_gen: SETTLE/RUN lock FSM driving NUM_CH phase-aligned enable channels.
// Define CLKGEN_SQUARE_OUT_EN to add the per-channel square-wave output sq.
`timescale 1ns/1ps
module clk_enable_gen
    import clkgen_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 16
) (
    input  logic          refclk,
    input  logic          rst,
    clk_enable_gen_if.slave io_bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

    state_t            r_state;
    logic [SET_W-1:0]  r_settle;
    logic              r_locked;
    logic              w_accept;
    logic              w_run;
    logic              w_run_next;
    logic [NUM_CH-1:0] w_ce;

    assign io_bus.cfg_ready = !rst;
    assign w_accept         = io_bus.cfg_valid && !rst;
    assign w_run            = (r_state == RUN);
    // A write on the SETTLE->RUN cycle wins and keeps the block settling.
    assign w_run_next       = !rst && !w_accept && (w_run || (r_settle == SET_LAST));

    always_ff @(posedge refclk) begin
        if (rst || w_accept) begin
            r_state  <= SETTLE;
            r_settle <= '0;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                SETTLE: begin
                    if (r_settle == SET_LAST) begin
                        r_state  <= RUN;
                        r_locked <= 1'b1;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                RUN: r_locked <= 1'b1;
            endcase
        end
    end

    assign io_bus.locked = r_locked;
    assign io_bus.ce     = w_ce;

`ifdef CLKGEN_SQUARE_OUT_EN
    logic [NUM_CH-1:0] w_sq;
    assign io_bus.sq = w_sq;
`endif

    // Writes to channel indices >= NUM_CH match no channel but still restart the settle.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkgen_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .refclk     (refclk),
            .rst        (rst),
            .i_wr       (w_accept && (io_bus.cfg_ch == CH_W'(g))),
            .i_div      (io_bus.cfg_div),
            .i_phase    (io_bus.cfg_phase),
            .i_run      (w_run),
            .i_run_next (w_run_next),
            .o_ce       (w_ce[g])
`ifdef CLKGEN_SQUARE_OUT_EN
            ,
            .o_sq       (w_sq[g])
`endif
        );
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed scenarios plus random writes/resets
// compared every cycle against a period/phase arithmetic model.
`timescale 1ns/1ps
module tb_clk_enable_gen;
    localparam int NUM_CH      = 3;
    localparam int CNT_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    clk_enable_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_enable_gen #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 refclk = ~refclk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int sst    = 0;
    int mdl_div [NUM_CH];
    int mdl_ph  [NUM_CH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // First locked cycle is sst+LOCK_CYCLES; ce fires at phase, phase+div, ... after that.
    function automatic bit exp_ce(input int i);
        int k;
        k = cyc - (sst + LOCK_CYCLES);
        if (k < mdl_ph[i]) return 1'b0;
        return ((k - mdl_ph[i]) % mdl_div[i]) == 0;
    endfunction

`ifdef CLKGEN_SQUARE_OUT_EN
    function automatic bit exp_sq(input int i);
        int k, m;
        k = cyc - (sst + LOCK_CYCLES);
        if (k < 0) return 1'b0;
        m = (k - mdl_ph[i]) % mdl_div[i];
        if (m < 0) m += mdl_div[i];
        return m < (mdl_div[i] + 1) / 2;
    endfunction
`endif

    task automatic mdl_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            mdl_div[i] = 1;
            mdl_ph[i]  = 0;
        end
    endtask

    task automatic step(input bit r, input bit v, input int ch, input int d, input int p);
        logic [NUM_CH-1:0] e_ce;
        logic [NUM_CH-1:0] e_sq;
        bit e_lk;
        rst           = r;
        bus.cfg_valid = v;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_div   = CNT_W'(d);
        bus.cfg_phase = CNT_W'(p);
        #2;
        if (cyc > 0) begin
            e_lk = (cyc >= sst + LOCK_CYCLES);
            for (int i = 0; i < NUM_CH; i++) begin
                e_ce[i] = exp_ce(i);
`ifdef CLKGEN_SQUARE_OUT_EN
                e_sq[i] = exp_sq(i);
`else
                e_sq[i] = 1'b0;
`endif
            end
            check_eq("locked", 32'(bus.locked), 32'(e_lk));
            check_eq("ce", 32'(bus.ce), 32'(e_ce));
            check_eq("cfg_ready", 32'(bus.cfg_ready), 32'(!r));
`ifdef CLKGEN_SQUARE_OUT_EN
            check_eq("sq", 32'(bus.sq), 32'(e_sq));
`endif
        end
        if (r) begin
            mdl_reset();
            sst = cyc + 1;
        end else if (v) begin
            if (ch < NUM_CH) begin
                mdl_div[ch] = (d == 0) ? 1 : d;
                mdl_ph[ch]  = (p > mdl_div[ch] - 1) ? mdl_div[ch] - 1 : p;
            end
            sst = cyc + 1;
        end
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic wr(input int ch, input int d, input int p);
        step(1'b0, 1'b1, ch, d, p);
    endtask

    initial begin
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_div   = '0;
        bus.cfg_phase = '0;
        mdl_reset();
        @(posedge refclk);
        #1;
        cyc = 0;

        // Reset, then defaults: all enables high once locked.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0);
        idle(24);

        // Back-to-back writes, ch1 phase-offset by 2.
        wr(0, 4, 0);
        wr(1, 4, 2);
        idle(30);

        // div=0 treated as 1; phase clamped to div-1.
        wr(2, 0, 5);
        wr(0, 4, 7);
        idle(30);

        // Write mid-settle restarts the settle period.
        wr(1, 3, 1);
        idle(10);
        wr(1, 6, 4);
        idle(25);

        // Write on the SETTLE->RUN cycle keeps the block settling.
        wr(0, 2, 1);
        idle(LOCK_CYCLES - 1);
        wr(1, 5, 0);
        idle(25);

        // Ignored channel index still re-settles.
        wr(3, 7, 2);
        idle(22);

        // Reset together with a write: write dropped, channels back to div=1.
        step(1'b1, 1'b1, 0, 7, 1);
        step(1'b1, 1'b0, 0, 0, 0);
        idle(22);

        // Square-wave pattern on div=5.
        wr(0, 5, 0);
        idle(30);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(199, 0) == 0) begin
                step(1'b1, 1'($urandom_range(1, 0)), 0, 0, 0);
            end else if ($urandom_range(19, 0) == 0) begin
                wr(int'($urandom_range(3, 0)), int'($urandom_range(9, 0)), int'($urandom_range(12, 0)));
            end else begin
                idle(1);
            end
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

endmodule
